// File: rtl/lmem_pkg.sv
// Shared definitions for the layer-memory arbiter: owner FSM state
// encoding, bank-select codes, and default address/data widths.
package lmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    localparam logic [2:0] SEL_NONE = 3'd0;
    localparam logic [2:0] SEL_L0K0 = 3'd1;
    localparam logic [2:0] SEL_L0K1 = 3'd2;
    localparam logic [2:0] SEL_L1K0 = 3'd3;
    localparam logic [2:0] SEL_L1K1 = 3'd4;
    localparam logic [2:0] SEL_L2   = 3'd5;

    localparam int unsigned LMEM_AW = 12;
    localparam int unsigned LMEM_DW = 20;

endpackage

// File: rtl/lmem_arb_fsm.sv
// Owner FSM for lmem_arb: selects which master owns the memory port,
// tracks the burst length of the current owner and the round-robin pointer.
//   clk, reset_n     : clock, async active-low reset
//   req0/1, lock0/1  : master requests and ownership locks
//   gnt0/1           : command accepted this cycle
//   state            : current owner state
// Build option LMEM_ARB_FIXPRI_EN: M0 wins ties and is never preempted by
// the burst limit; no round-robin pointer is built.
module lmem_arb_fsm
    import lmem_pkg::*;
#(
    parameter int unsigned MAX_BURST = 16
)
(
    input  logic   clk,
    input  logic   reset_n,
    input  logic   req0,
    input  logic   req1,
    input  logic   lock0,
    input  logic   lock1,
    output logic   gnt0,
    output logic   gnt1,
    output state_e state
);

    localparam int unsigned   CW      = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

    state_e        state_nxt;
    logic [CW-1:0] cnt;
    logic          own_req;
    logic          other_req;
    logic          own_lock;
    logic          expire;
`ifndef LMEM_ARB_FIXPRI_EN
    logic          ptr;     // last master that owned the port
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
`ifndef LMEM_ARB_FIXPRI_EN
            ptr   <= 1'b1;
`endif
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                cnt <= '0;
            else if ((gnt0 || gnt1) && (cnt != CNT_MAX))
                cnt <= cnt + CW'(1);
`ifndef LMEM_ARB_FIXPRI_EN
            if (state == OWN0 && state_nxt != OWN0)
                ptr <= 1'b0;
            else if (state == OWN1 && state_nxt != OWN1)
                ptr <= 1'b1;
`endif
        end
    end

    always_comb begin
        own_req   = (state == OWN1) ? req1  : req0;
        other_req = (state == OWN1) ? req0  : req1;
        own_lock  = (state == OWN1) ? lock1 : lock0;
        expire    = (state != IDLE) && (cnt == CNT_MAX) && other_req && !own_lock;
`ifdef LMEM_ARB_FIXPRI_EN
        if (state != OWN1)
            expire = 1'b0;
`endif
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (req0 && req1) begin
`ifdef LMEM_ARB_FIXPRI_EN
                    state_nxt = OWN0;
`else
                    state_nxt = ptr ? OWN0 : OWN1;
`endif
                end else if (req0) begin
                    state_nxt = OWN0;
                end else if (req1) begin
                    state_nxt = OWN1;
                end
            end
            OWN0: begin
                if (expire || (!own_req && other_req))
                    state_nxt = OWN1;
                else if (!own_req)
                    state_nxt = IDLE;
            end
            OWN1: begin
                if (expire || (!own_req && other_req))
                    state_nxt = OWN0;
                else if (!own_req)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt0 = (state == OWN0) && req0 && !expire;
        gnt1 = (state == OWN1) && req1 && !expire;
    end

endmodule

// File: rtl/lmem_arb.sv
// Two-master arbiter for the shared layer-memory port.
//   clk, reset_n                 : clock, async active-low reset
//   mN_req/lock/we/sel/addr/wdata: master N command inputs (N=0,1)
//   mN_gnt                       : master N command accepted this cycle
//   mN_rvalid/mN_rdata           : read return to the issuing master
//   csel/crd/cwr/caddr_rd/caddr_wr/cdata_wr : registered memory strobes
//   cdata_rd                     : memory read data, valid with crd
//   busy                         : port owned or transaction in flight
// Build option LMEM_ARB_FIXPRI_EN selects fixed M0 priority in the FSM.
module lmem_arb
    import lmem_pkg::*;
#(
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned AW        = LMEM_AW,
    parameter int unsigned DW        = LMEM_DW
)
(
    input  logic          clk,
    input  logic          reset_n,
    input  logic          m0_req,
    input  logic          m0_lock,
    input  logic          m0_we,
    input  logic [2:0]    m0_sel,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_lock,
    input  logic          m1_we,
    input  logic [2:0]    m1_sel,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic [2:0]    csel,
    output logic          crd,
    output logic          cwr,
    output logic [AW-1:0] caddr_rd,
    output logic [AW-1:0] caddr_wr,
    output logic [DW-1:0] cdata_wr,
    input  logic [DW-1:0] cdata_rd,
    output logic          busy
);

    state_e        state;
    logic          accept;
    logic          c_we;
    logic [2:0]    c_sel;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata;
    logic          rd_tag;  // master that issued the read now on crd

    lmem_arb_fsm #(
        .MAX_BURST (MAX_BURST)
    ) u_fsm (
        .clk     (clk),
        .reset_n (reset_n),
        .req0    (m0_req),
        .req1    (m1_req),
        .lock0   (m0_lock),
        .lock1   (m1_lock),
        .gnt0    (m0_gnt),
        .gnt1    (m1_gnt),
        .state   (state)
    );

    always_comb begin
        accept  = m0_gnt || m1_gnt;
        c_we    = m1_gnt ? m1_we    : m0_we;
        c_sel   = m1_gnt ? m1_sel   : m0_sel;
        c_addr  = m1_gnt ? m1_addr  : m0_addr;
        c_wdata = m1_gnt ? m1_wdata : m0_wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csel      <= SEL_NONE;
            crd       <= 1'b0;
            cwr       <= 1'b0;
            caddr_rd  <= '0;
            caddr_wr  <= '0;
            cdata_wr  <= '0;
            rd_tag    <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            crd  <= accept && !c_we;
            cwr  <= accept && c_we;
            csel <= accept ? c_sel : SEL_NONE;
            if (accept) begin
                rd_tag <= m1_gnt;
                if (c_we) begin
                    caddr_wr <= c_addr;
                    cdata_wr <= c_wdata;
                end else begin
                    caddr_rd <= c_addr;
                end
            end
            // The owner tag rides with the strobe, so a hand-over between
            // accept and return cannot redirect the data.
            m0_rvalid <= crd && !rd_tag;
            m1_rvalid <= crd && rd_tag;
            if (crd) begin
                if (rd_tag)
                    m1_rdata <= cdata_rd;
                else
                    m0_rdata <= cdata_rd;
            end
        end
    end

    always_comb begin
        busy = (state != IDLE) || crd || cwr || m0_rvalid || m1_rvalid;
    end

endmodule
